// File: rtl/modulo_controle_contagem.sv
// modulo_controle_contagem: 2-digit BCD countdown controller with start/pause/load buttons.
// Ports:
//   clk        - system clock, all state updates on rising edge
//   clr        - asynchronous active-low reset
//   btn_start  - raw start/pause button (active-high, asynchronous)
//   btn_load   - raw load button (active-high, asynchronous)
//   load_val   - BCD value loaded on a load press ([7:4] tens, [3:0] units)
//   tick       - one-cycle timebase enable, one count step per tick
//   count      - registered BCD count
//   t_vec      - toggle enables for a downstream T flip-flop bank (count ^ next count)
//   running    - high while counting
//   done       - one-cycle pulse when the count reaches 00
// Build option: define AUTO_RELOAD_EN to reload PRESET at the end of a count and keep running.
module modulo_controle_contagem #(
    parameter logic [7:0] PRESET = 8'h59
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic [7:0] count,
    output logic [7:0] t_vec,
    output logic       running,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    function automatic logic [7:0] sat(input logic [7:0] v);
        return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
    endfunction

    localparam logic [7:0] PRESET_SAT = sat(PRESET);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       done_q, done_d;
    logic [2:0] st_sync, ld_sync;
    logic [1:0] vld;
    logic       st_arm, ld_arm;
    logic       st_edge, ld_edge;
    logic [7:0] dec;

    // Synchronisers plus edge detectors. vld[1] marks that the second sync stage
    // holds a real sample; an edge is only armed once the button has been seen
    // low after that, so a button held through reset release is ignored.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            st_sync <= '0;
            ld_sync <= '0;
            vld     <= '0;
            st_arm  <= 1'b0;
            ld_arm  <= 1'b0;
        end else begin
            st_sync <= {st_sync[1:0], btn_start};
            ld_sync <= {ld_sync[1:0], btn_load};
            vld     <= {vld[0], 1'b1};
            st_arm  <= st_arm | (vld[1] & ~st_sync[1]);
            ld_arm  <= ld_arm | (vld[1] & ~ld_sync[1]);
        end
    end

    assign st_edge = st_sync[1] & ~st_sync[2] & st_arm;
    assign ld_edge = ld_sync[1] & ~ld_sync[2] & ld_arm;

    // BCD decrement, floored at 00
    assign dec = (count_q == 8'h00) ? 8'h00 :
                 (count_q[3:0] == 4'd0) ? {count_q[7:4] - 4'd1, 4'd9} :
                 {count_q[7:4], count_q[3:0] - 4'd1};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            count_q <= PRESET_SAT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Load wins over start wherever both are honoured; in RUN load is ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_edge) count_d = sat(load_val);
                else if (st_edge && count_q != 8'h00) state_d = RUN;
            end
            RUN: begin
                if (st_edge) state_d = PAUSE;
                else if (tick) begin
                    count_d = dec;
                    if (count_q == 8'h01) begin
                        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        count_d = PRESET_SAT;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            PAUSE: begin
                if (ld_edge) begin
                    count_d = sat(load_val);
                    state_d = IDLE;
                end else if (st_edge) state_d = RUN;
            end
            DONE: begin
                if (ld_edge) begin
                    count_d = sat(load_val);
                    state_d = IDLE;
                end else if (st_edge) begin
                    count_d = PRESET_SAT;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign done    = done_q;
    // count_d is exactly the stepped value whenever a tick is honoured in RUN
    assign t_vec   = (running && tick && !st_edge) ? (count_q ^ count_d) : 8'h00;
endmodule

// File: tb/tb_modulo_controle_contagem.sv
module tb_modulo_controle_contagem;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       tick = 1'b0;
    logic [7:0] count, t_vec;
    logic       running, done;

    int tests = 0;
    int fails = 0;

    int         m_state, m_val;
    bit         m_done;
    logic [7:0] exp_tvec;
    logic [7:0] obs_tvec, obs_count;
    logic       obs_run, obs_done, obs_done2;

    modulo_controle_contagem dut (
        .clk(clk), .clr(clr), .btn_start(btn_start), .btn_load(btn_load),
        .load_val(load_val), .tick(tick), .count(count), .t_vec(t_vec),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int satv(input logic [7:0] v);
        int t, u;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        u = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + u;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_val   = 59;
        m_done  = 1'b0;
    endtask

    task automatic model(input bit st, input bit ld, input bit tk, input logic [7:0] lv);
        int old, ps;
        old = m_val;
        ps  = m_state;
        m_done = 1'b0;
        case (m_state)
            S_IDLE: begin
                if (ld) m_val = satv(lv);
                else if (st && m_val != 0) m_state = S_RUN;
            end
            S_RUN: begin
                if (st) m_state = S_PAUSE;
                else if (tk) begin
                    if (m_val == 1) begin
                        m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
                        m_val = 59;
`else
                        m_val = 0;
                        m_state = S_DONE;
`endif
                    end else if (m_val > 0) m_val = m_val - 1;
                end
            end
            S_PAUSE: begin
                if (ld) begin m_val = satv(lv); m_state = S_IDLE; end
                else if (st) m_state = S_RUN;
            end
            default: begin
                if (ld) begin m_val = satv(lv); m_state = S_IDLE; end
                else if (st) begin m_val = 59; m_state = S_IDLE; end
            end
        endcase
        exp_tvec = (ps == S_RUN && tk && !st) ? (bcd(old) ^ bcd(m_val)) : 8'h00;
    endtask

    // One honoured step: buttons (if any) are pressed so their edges land on the
    // same rising edge as the chosen tick. Must be called at a falling edge.
    task automatic step(input bit st, input bit ld, input bit tk, input logic [7:0] lv);
        btn_start = st;
        btn_load  = ld;
        load_val  = lv;
        if (st || ld) begin
            @(posedge clk); @(negedge clk);
            @(posedge clk); @(negedge clk);
        end
        tick = tk;
        model(st, ld, tk, lv);
        #1 obs_tvec = t_vec;
        @(posedge clk); @(negedge clk);
        tick = 1'b0;
        btn_start = 1'b0;
        btn_load = 1'b0;
        obs_count = count;
        obs_run   = running;
        obs_done  = done;
        @(posedge clk); @(negedge clk);
        obs_done2 = done;
        if (st || ld) repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (count !== 8'h59 || running !== 1'b0 || done !== 1'b0 || t_vec !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold: count=%h run=%b done=%b t_vec=%h, want 59/0/0/00", count, running, done, t_vec);
        end
        clr = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (count !== 8'h59 || running !== 1'b0 || done !== 1'b0 || t_vec !== 8'h00) begin
            fails++;
            $display("FAIL reset_release: count=%h run=%b done=%b t_vec=%h, want 59/0/0/00", count, running, done, t_vec);
        end
    endtask

    task automatic test_load_start_tick();
        step(0, 1, 0, 8'h10);
        tests++;
        if (obs_count !== 8'h10 || obs_run !== 1'b0) begin
            fails++;
            $display("FAIL load_10: count=%h run=%b, want 10/0", obs_count, obs_run);
        end
        step(1, 0, 0, 8'h00);
        tests++;
        if (obs_run !== 1'b1) begin
            fails++;
            $display("FAIL start_run: run=%b, want 1", obs_run);
        end
        step(0, 0, 1, 8'h00);
        tests++;
        if (obs_tvec !== 8'h19 || obs_count !== 8'h09) begin
            fails++;
            $display("FAIL tick_borrow: t_vec=%h count=%h, want 19/09", obs_tvec, obs_count);
        end
    endtask

    task automatic test_countdown_done();
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h02);
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        tests++;
        if (obs_count !== 8'h01 || obs_done !== 1'b0 || obs_tvec !== 8'h03) begin
            fails++;
            $display("FAIL count_01: count=%h done=%b t_vec=%h, want 01/0/03", obs_count, obs_done, obs_tvec);
        end
        step(0, 0, 1, 8'h00);
        tests++;
        if (obs_count !== bcd(m_val) || obs_done !== 1'b1 || obs_done2 !== 1'b0 || obs_run !== (m_state == S_RUN)) begin
            fails++;
            $display("FAIL reach_zero: count=%h done=%b done_next=%b run=%b, want %h/1/0/%0d",
                     obs_count, obs_done, obs_done2, obs_run, bcd(m_val), m_state == S_RUN);
        end
`ifndef AUTO_RELOAD_EN
        step(0, 0, 1, 8'h00);
        tests++;
        if (obs_count !== 8'h00 || obs_tvec !== 8'h00 || obs_done !== 1'b0) begin
            fails++;
            $display("FAIL done_hold: count=%h t_vec=%h done=%b, want 00/00/0", obs_count, obs_tvec, obs_done);
        end
`else
        tests++;
        if (obs_count !== 8'h59 || obs_run !== 1'b1) begin
            fails++;
            $display("FAIL auto_reload: count=%h run=%b, want 59/1", obs_count, obs_run);
        end
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
`endif
    endtask

    task automatic test_pause();
        step(0, 1, 0, 8'h30);
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'h00);
        tests++;
        if (obs_count !== 8'h30 || obs_tvec !== 8'h00 || obs_run !== 1'b0) begin
            fails++;
            $display("FAIL pause_tick: count=%h t_vec=%h run=%b, want 30/00/0", obs_count, obs_tvec, obs_run);
        end
        step(0, 0, 1, 8'h00);
        tests++;
        if (obs_count !== 8'h30) begin
            fails++;
            $display("FAIL pause_hold: count=%h, want 30", obs_count);
        end
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        tests++;
        if (obs_run !== 1'b1 || obs_count !== 8'h29 || obs_tvec !== 8'h19) begin
            fails++;
            $display("FAIL resume: run=%b count=%h t_vec=%h, want 1/29/19", obs_run, obs_count, obs_tvec);
        end
    endtask

    task automatic test_saturation_priority();
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'hAF);
        step(0, 1, 0, 8'hAF);
        tests++;
        if (obs_count !== 8'h99 || obs_run !== 1'b0) begin
            fails++;
            $display("FAIL saturate: count=%h run=%b, want 99/0", obs_count, obs_run);
        end
        step(1, 0, 0, 8'h00);
        step(0, 1, 1, 8'h11);
        tests++;
        if (obs_count !== 8'h98 || obs_run !== 1'b1) begin
            fails++;
            $display("FAIL run_ignores_load: count=%h run=%b, want 98/1", obs_count, obs_run);
        end
        step(1, 0, 0, 8'h00);
        step(1, 1, 0, 8'h25);
        tests++;
        if (obs_count !== 8'h25 || obs_run !== 1'b0) begin
            fails++;
            $display("FAIL load_priority: count=%h run=%b, want 25/0", obs_count, obs_run);
        end
        step(1, 0, 0, 8'h00);
        tests++;
        if (obs_run !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_priority: run=%b, want 1", obs_run);
        end
    endtask

    task automatic test_reset_midcount();
        step(0, 0, 1, 8'h00);
        #2 clr = 1'b0;
        #1;
        tests++;
        if (count !== 8'h59 || running !== 1'b0 || done !== 1'b0 || t_vec !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: count=%h run=%b done=%b t_vec=%h, want 59/0/0/00", count, running, done, t_vec);
        end
        model_reset();
        btn_start = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (running !== 1'b0 || count !== 8'h59) begin
            fails++;
            $display("FAIL held_button: run=%b count=%h, want 0/59", running, count);
        end
        btn_start = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (running !== 1'b0) begin
            fails++;
            $display("FAIL held_release: run=%b, want 0", running);
        end
        step(1, 0, 0, 8'h00);
        tests++;
        if (obs_run !== 1'b1) begin
            fails++;
            $display("FAIL rearm_start: run=%b, want 1", obs_run);
        end
    endtask

    task automatic test_random();
        bit st, ld, tk;
        logic [7:0] lv;
        for (int i = 0; i < 120; i++) begin
            st = ($urandom_range(0, 5) == 0);
            ld = ($urandom_range(0, 6) == 0);
            tk = ($urandom_range(0, 3) != 0);
            lv = 8'($urandom);
            if ($urandom_range(0, 1) == 0) lv = bcd($urandom_range(0, 12));
            step(st, ld, tk, lv);
            tests++;
            if (obs_tvec !== exp_tvec || obs_count !== bcd(m_val) || obs_run !== (m_state == S_RUN) ||
                obs_done !== m_done || obs_done2 !== 1'b0) begin
                fails++;
                $display("FAIL random[%0d] st=%b ld=%b tk=%b lv=%h: t_vec=%h count=%h run=%b done=%b/%b, want %h/%h/%0d/%b/0",
                         i, st, ld, tk, lv, obs_tvec, obs_count, obs_run, obs_done, obs_done2,
                         exp_tvec, bcd(m_val), m_state == S_RUN, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_start_tick();
        test_countdown_done();
        test_pause();
        test_saturation_priority();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
